// File: rtl/qrd_ctrl.sv
// Sequencer around a 4x5 QRD core: loads [H|y] (20 beats), skews rows into the core, collects [R|Q^H y], drains 20 beats.
// Issue starts the cycle after q_in_ready; m_valid follows cc=7 by one cycle; optional QRD_CTRL_TIMEOUT_EN aborts on a silent core.
module qrd_ctrl #(
   parameter int DW      = 14,
   parameter int TIMEOUT = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [DW-1:0] s_data_r,
   input  logic [DW-1:0] s_data_i,
   output logic [DW-1:0] q_row_in_1_r,
   output logic [DW-1:0] q_row_in_1_i,
   output logic [DW-1:0] q_row_in_2_r,
   output logic [DW-1:0] q_row_in_2_i,
   output logic [DW-1:0] q_row_in_3_r,
   output logic [DW-1:0] q_row_in_3_i,
   output logic [DW-1:0] q_row_in_4_r,
   output logic [DW-1:0] q_row_in_4_i,
   output logic          q_row_in_1_f,
   output logic          q_row_in_2_f,
   output logic          q_row_in_3_f,
   input  logic          q_in_ready,
   input  logic          q_out_valid,
   input  logic [DW-1:0] q_row_out_1_r,
   input  logic [DW-1:0] q_row_out_1_i,
   input  logic [DW-1:0] q_row_out_2_r,
   input  logic [DW-1:0] q_row_out_2_i,
   input  logic [DW-1:0] q_row_out_3_r,
   input  logic [DW-1:0] q_row_out_3_i,
   input  logic [DW-1:0] q_row_out_4_r,
   input  logic [DW-1:0] q_row_out_4_i,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [DW-1:0] m_data_r,
   output logic [DW-1:0] m_data_i,
   output logic          m_last,
   output logic          busy,
   output logic          err
);

   typedef enum logic [1:0] {LOAD, START, EXEC, DRAIN} state_t;
   state_t state, state_nx;

   logic [DW-1:0] in_r [20];
   logic [DW-1:0] in_i [20];
   logic [DW-1:0] res_r [20];
   logic [DW-1:0] res_i [20];
   logic [DW-1:0] qi_r [4];
   logic [DW-1:0] qi_i [4];
   logic [DW-1:0] qi_r_nx [4];
   logic [DW-1:0] qi_i_nx [4];
   logic [DW-1:0] qo_r [4];
   logic [DW-1:0] qo_i [4];
   logic [2:0]    qf, qf_nx;

   logic [4:0] lidx, oidx;
   logic [2:0] ic, cc, cc_eff, iss_ic;
   logic       issue_done, cap_run, cap_done;
   logic       s_fire, m_fire, cap_now, exec_done, iss_en, timeout_hit;

   assign qo_r = '{q_row_out_1_r, q_row_out_2_r, q_row_out_3_r, q_row_out_4_r};
   assign qo_i = '{q_row_out_1_i, q_row_out_2_i, q_row_out_3_i, q_row_out_4_i};

   assign s_fire    = s_valid && s_ready;
   assign m_valid   = (state == DRAIN);
   assign m_fire    = m_valid && m_ready;
   assign m_last    = m_valid && (oidx == 5'd19);
   assign m_data_r  = m_valid ? res_r[oidx] : '0;
   assign m_data_i  = m_valid ? res_i[oidx] : '0;
   assign busy      = (state != LOAD);

   // Capture counter starts on the first q_out_valid and then free-runs for 8 cycles.
   assign cap_now   = (state == EXEC) && !cap_done && (cap_run || q_out_valid);
   assign cc_eff    = cap_run ? cc : 3'd0;
   assign exec_done = (issue_done || ic == 3'd7) && (cap_done || (cap_now && cc_eff == 3'd7));

`ifdef QRD_CTRL_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tcnt;
   logic          err_q;

   assign timeout_hit = (state == EXEC) && !cap_run && !cap_done && !q_out_valid &&
                        (tcnt == TW'(TIMEOUT - 1));
   assign err = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tcnt  <= '0;
         err_q <= 1'b0;
      end else begin
         if (state != EXEC)
            tcnt <= '0;
         else if (!timeout_hit && !cap_run && !cap_done)
            tcnt <= tcnt + TW'(1);
         if (timeout_hit)
            err_q <= 1'b1;
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
   assign timeout_hit    = 1'b0;
   assign err            = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      case (state)
         LOAD:    if (s_fire && lidx == 5'd19) state_nx = START;
         START:   if (q_in_ready) state_nx = EXEC;
         EXEC:    if (timeout_hit) state_nx = LOAD;
                  else if (exec_done) state_nx = DRAIN;
         DRAIN:   if (m_fire && oidx == 5'd19) state_nx = LOAD;
         default: state_nx = LOAD;
      endcase
   end

   // Row k (0-based) carries column ic-k of its row; the registers hold the value for the ic shown next cycle.
   always_comb begin
      iss_en = 1'b0;
      iss_ic = 3'd0;
      if (state == START && q_in_ready) begin
         iss_en = 1'b1;
      end else if (state == EXEC && !issue_done && ic != 3'd7 && !timeout_hit) begin
         iss_en = 1'b1;
         iss_ic = ic + 3'd1;
      end
      qf_nx = 3'b000;
      for (int k = 0; k < 4; k++) begin
         qi_r_nx[k] = '0;
         qi_i_nx[k] = '0;
         if (iss_en && int'(iss_ic) >= k && int'(iss_ic) <= k + 4) begin
            qi_r_nx[k] = in_r[5'(4 * k + int'(iss_ic))];
            qi_i_nx[k] = in_i[5'(4 * k + int'(iss_ic))];
         end
      end
      if (iss_en) qf_nx = {iss_ic == 3'd4, iss_ic == 3'd2, iss_ic == 3'd0};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= LOAD;
         s_ready    <= 1'b0;
         lidx       <= '0;
         oidx       <= '0;
         ic         <= '0;
         cc         <= '0;
         issue_done <= 1'b0;
         cap_run    <= 1'b0;
         cap_done   <= 1'b0;
         qf         <= '0;
         for (int k = 0; k < 4; k++) begin
            qi_r[k] <= '0;
            qi_i[k] <= '0;
         end
      end else begin
         state   <= state_nx;
         s_ready <= (state_nx == LOAD);
         if (s_fire) lidx <= (lidx == 5'd19) ? 5'd0 : lidx + 5'd1;
         if (m_fire) oidx <= (oidx == 5'd19) ? 5'd0 : oidx + 5'd1;
         if (state == START && q_in_ready) begin
            ic         <= '0;
            cc         <= '0;
            issue_done <= 1'b0;
            cap_run    <= 1'b0;
            cap_done   <= 1'b0;
         end else if (state == EXEC) begin
            if (!issue_done) begin
               if (ic == 3'd7) issue_done <= 1'b1;
               else            ic <= ic + 3'd1;
            end
            if (cap_now) begin
               if (cc_eff == 3'd7) begin
                  cap_done <= 1'b1;
                  cap_run  <= 1'b0;
               end else begin
                  cc      <= cc_eff + 3'd1;
                  cap_run <= 1'b1;
               end
            end
         end
         qf <= qf_nx;
         for (int k = 0; k < 4; k++) begin
            qi_r[k] <= qi_r_nx[k];
            qi_i[k] <= qi_i_nx[k];
         end
      end
   end

   // Sample storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (s_fire) begin
         in_r[lidx] <= s_data_r;
         in_i[lidx] <= s_data_i;
      end
      if (cap_now) begin
         for (int k = 0; k < 4; k++) begin
            if (int'(cc_eff) >= k && int'(cc_eff) <= k + 4) begin
               res_r[5'(4 * k + int'(cc_eff))] <= qo_r[k];
               res_i[5'(4 * k + int'(cc_eff))] <= qo_i[k];
            end
         end
      end
   end

   assign q_row_in_1_r = qi_r[0];
   assign q_row_in_1_i = qi_i[0];
   assign q_row_in_2_r = qi_r[1];
   assign q_row_in_2_i = qi_i[1];
   assign q_row_in_3_r = qi_r[2];
   assign q_row_in_3_i = qi_i[2];
   assign q_row_in_4_r = qi_r[3];
   assign q_row_in_4_i = qi_i[3];
   assign q_row_in_1_f = qf[0];
   assign q_row_in_2_f = qf[1];
   assign q_row_in_3_f = qf[2];

endmodule

// File: tb/tb_qrd_ctrl.sv
// Randomized bench for qrd_ctrl: a matrix-level model of load/issue/capture/drain plus a toy QRD core.
module tb_qrd_ctrl;
   localparam int DW      = 14;
   localparam int TIMEOUT = 64;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          s_valid, s_ready, q_in_ready, q_out_valid;
   logic          m_valid, m_ready, m_last, busy, err;
   logic [DW-1:0] s_data_r, s_data_i, m_data_r, m_data_i;
   logic [DW-1:0] q_row_in_1_r, q_row_in_1_i, q_row_in_2_r, q_row_in_2_i;
   logic [DW-1:0] q_row_in_3_r, q_row_in_3_i, q_row_in_4_r, q_row_in_4_i;
   logic          q_row_in_1_f, q_row_in_2_f, q_row_in_3_f;
   logic [DW-1:0] q_row_out_1_r, q_row_out_1_i, q_row_out_2_r, q_row_out_2_i;
   logic [DW-1:0] q_row_out_3_r, q_row_out_3_i, q_row_out_4_r, q_row_out_4_i;
   logic [DW-1:0] qo_r [4];
   logic [DW-1:0] qo_i [4];

   logic [DW-1:0] h_r [20];
   logic [DW-1:0] h_i [20];
   logic [DW-1:0] x_r [20];
   logic [DW-1:0] x_i [20];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   assign q_row_out_1_r = qo_r[0];
   assign q_row_out_1_i = qo_i[0];
   assign q_row_out_2_r = qo_r[1];
   assign q_row_out_2_i = qo_i[1];
   assign q_row_out_3_r = qo_r[2];
   assign q_row_out_3_i = qo_i[2];
   assign q_row_out_4_r = qo_r[3];
   assign q_row_out_4_i = qo_i[3];

   qrd_ctrl #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid), .s_ready(s_ready), .s_data_r(s_data_r), .s_data_i(s_data_i),
      .q_row_in_1_r(q_row_in_1_r), .q_row_in_1_i(q_row_in_1_i),
      .q_row_in_2_r(q_row_in_2_r), .q_row_in_2_i(q_row_in_2_i),
      .q_row_in_3_r(q_row_in_3_r), .q_row_in_3_i(q_row_in_3_i),
      .q_row_in_4_r(q_row_in_4_r), .q_row_in_4_i(q_row_in_4_i),
      .q_row_in_1_f(q_row_in_1_f), .q_row_in_2_f(q_row_in_2_f), .q_row_in_3_f(q_row_in_3_f),
      .q_in_ready(q_in_ready), .q_out_valid(q_out_valid),
      .q_row_out_1_r(q_row_out_1_r), .q_row_out_1_i(q_row_out_1_i),
      .q_row_out_2_r(q_row_out_2_r), .q_row_out_2_i(q_row_out_2_i),
      .q_row_out_3_r(q_row_out_3_r), .q_row_out_3_i(q_row_out_3_i),
      .q_row_out_4_r(q_row_out_4_r), .q_row_out_4_i(q_row_out_4_i),
      .m_valid(m_valid), .m_ready(m_ready), .m_data_r(m_data_r), .m_data_i(m_data_i),
      .m_last(m_last), .busy(busy), .err(err)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [8*DW+2:0] obs_in();
      return {q_row_in_1_r, q_row_in_1_i, q_row_in_2_r, q_row_in_2_i,
              q_row_in_3_r, q_row_in_3_i, q_row_in_4_r, q_row_in_4_i,
              q_row_in_1_f, q_row_in_2_f, q_row_in_3_f};
   endfunction

   // Issue step t: row k presents H(k, t-k) inside its 5-step window, zero elsewhere.
   function automatic logic [8*DW+2:0] exp_in(input int t);
      logic [DW-1:0] er [4];
      logic [DW-1:0] ei [4];
      for (int k = 0; k < 4; k++) begin
         er[k] = '0;
         ei[k] = '0;
         if (t >= k && t <= k + 4) begin
            er[k] = h_r[k * 5 + (t - k)];
            ei[k] = h_i[k * 5 + (t - k)];
         end
      end
      return {er[0], ei[0], er[1], ei[1], er[2], ei[2], er[3], ei[3], t == 0, t == 2, t == 4};
   endfunction

   // Toy core: at output step cc row k presents result element (k, cc-k); junk outside its window.
   task automatic drive_core(input int cc);
      for (int k = 0; k < 4; k++) begin
         if (cc >= k && cc <= k + 4) begin
            qo_r[k] = x_r[k * 5 + (cc - k)];
            qo_i[k] = x_i[k * 5 + (cc - k)];
         end else begin
            qo_r[k] = DW'($urandom);
            qo_i[k] = DW'($urandom);
         end
      end
   endtask

   // One job; ovd = core delay after ic=0 (-1: core silent), mode = m_ready pattern, rst_t = issue step to reset at.
   task automatic run_job(input int qir_dly, input int ovd, input int mode, input bit hold_sv, input int rst_t);
      int b, n, t, beat;
      bit bad_acc, bad_start, gap, stall_prev, bad_to;
      logic [2*DW:0] held;
      for (int i = 0; i < 20; i++) begin
         h_r[i] = DW'($urandom);
         h_i[i] = DW'($urandom);
         x_r[i] = DW'($urandom);
         x_i[i] = DW'($urandom);
      end
      b = 0;
      n = 0;
      while (b < 20 && n < 400) begin
         s_valid     = ($urandom_range(0, 3) != 0);
         s_data_r    = h_r[b];
         s_data_i    = h_i[b];
         q_out_valid = 1'($urandom_range(0, 1));
         drive_core(-1);
         if (s_valid && s_ready) b++;
         @(negedge clk);
         n++;
      end
      chk("load_beats", b, 20);
      s_valid  = hold_sv;
      s_data_r = DW'($urandom);
      s_data_i = DW'($urandom);
      bad_acc  = 1'b0;
      chk("start_s_ready", s_ready, 0);
      bad_start = 1'b0;
      for (int i = 0; i < qir_dly; i++) begin
         q_in_ready  = 1'b0;
         q_out_valid = 1'($urandom_range(0, 1));
         drive_core(-1);
         if (s_ready !== 1'b0 || busy !== 1'b1 || obs_in() !== '0) bad_start = 1'b1;
         @(negedge clk);
      end
      chk("start_hold", bad_start, 0);
      q_in_ready  = 1'b1;
      q_out_valid = 1'($urandom_range(0, 1));
      drive_core(-1);
      @(negedge clk);
      t = 0;
      while (m_valid !== 1'b1 && t < 200) begin
         q_in_ready = 1'($urandom_range(0, 1));
         if (t == rst_t) begin
            rst_n = 1'b0;
            #1;
            chk("rst_mid_exec", {s_ready, busy, m_valid, m_last, err, m_data_r, m_data_i, obs_in()}, 0);
            @(negedge clk);
            rst_n       = 1'b1;
            s_valid     = 1'b0;
            q_out_valid = 1'b0;
            @(negedge clk);
            chk("rst_release_s_ready", s_ready, 1);
            return;
         end
         if (t <= 8) chk("issue", obs_in(), exp_in(t < 8 ? t : -1));
         if (s_ready) bad_acc = 1'b1;
         if (ovd >= 0 && t >= ovd) begin
            q_out_valid = (t == ovd) ? 1'b1 : 1'($urandom_range(0, 1));
            drive_core(t - ovd);
         end else begin
            q_out_valid = 1'b0;
            drive_core(-1);
         end
`ifdef QRD_CTRL_TIMEOUT_EN
         if (ovd < 0 && t == TIMEOUT - 1) chk("err_before_timeout", err, 0);
         if (ovd < 0 && t == TIMEOUT) begin
            chk("err_at_timeout", err, 1);
            chk("s_ready_after_timeout", s_ready, 1);
            s_valid = 1'b0;
            bad_to  = 1'b0;
            for (int i = 0; i < 10; i++) begin
               if (m_valid !== 1'b0 || err !== 1'b1) bad_to = 1'b1;
               @(negedge clk);
            end
            chk("no_m_after_timeout", bad_to, 0);
            return;
         end
`endif
         @(negedge clk);
         t++;
      end
      chk("drain_latency", t, ovd + 8);
      beat       = 0;
      n          = 0;
      gap        = 1'b0;
      stall_prev = 1'b0;
      held       = '0;
      while (beat < 20 && n < 400) begin
         case (mode)
            0:       m_ready = 1'b1;
            1:       m_ready = (n % 4 == 0) || (n % 4 == 3);
            default: m_ready = 1'($urandom_range(0, 1));
         endcase
         q_out_valid = 1'($urandom_range(0, 1));
         drive_core(-1);
         if (s_ready) bad_acc = 1'b1;
         if (m_valid !== 1'b1) gap = 1'b1;
         if (stall_prev) chk("m_hold", {m_data_r, m_data_i, m_last}, held);
         if (m_valid && m_ready) begin
            chk("m_data", {m_data_r, m_data_i}, {x_r[beat], x_i[beat]});
            chk("m_last", m_last, beat == 19);
            if (beat == 19) s_valid = 1'b0;
            beat++;
            stall_prev = 1'b0;
         end else begin
            stall_prev = m_valid;
            held       = {m_data_r, m_data_i, m_last};
         end
         @(negedge clk);
         n++;
      end
      m_ready = 1'b0;
      chk("drain_beats", beat, 20);
      chk("drain_no_gap", gap, 0);
      chk("idle_state", {s_ready, busy, m_valid}, 3'b100);
      if (hold_sv) chk("no_accept_while_busy", bad_acc, 0);
   endtask

   initial begin
      s_valid     = 1'b0;
      s_data_r    = '0;
      s_data_i    = '0;
      q_in_ready  = 1'b0;
      q_out_valid = 1'b0;
      m_ready     = 1'b0;
      drive_core(-1);
      repeat (2) @(negedge clk);
      chk("reset_outputs", {s_ready, busy, m_valid, m_last, err, obs_in()}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("s_ready_after_release", s_ready, 1);
      run_job(0, 5, 0, 1'b0, -1);
      run_job(10, 5, 0, 1'b0, -1);
      run_job(2, 3, 1, 1'b0, -1);
      run_job(0, 5, 0, 1'b0, 3);
      run_job(1, 4, 2, 1'b0, -1);
      run_job(0, 2, 0, 1'b1, -1);
      for (int j = 0; j < 6; j++)
         run_job($urandom_range(0, 6), $urandom_range(0, 10), $urandom_range(0, 2),
                 1'($urandom_range(0, 1)), -1);
`ifdef QRD_CTRL_TIMEOUT_EN
      run_job(0, -1, 0, 1'b0, -1);
`else
      run_job(0, 80, 0, 1'b0, -1);
      chk("err_tied_low", err, 0);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
